// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the ALU control decoder and mul/div sequencer
package alu_ctrl_pkg;

  localparam logic [1:0] OP_RTYPE = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_SLT   = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0010;
  localparam logic [3:0] FN_OR   = 4'b0011;
  localparam logic [3:0] FN_SLT  = 4'b0100;
  localparam logic [3:0] FN_MUL  = 4'b0101;
  localparam logic [3:0] FN_DIVU = 4'b0110;
  localparam logic [3:0] FN_REMU = 4'b0111;

  localparam logic [2:0] CNT_ADD = 3'b000;
  localparam logic [2:0] CNT_SUB = 3'b001;
  localparam logic [2:0] CNT_AND = 3'b010;
  localparam logic [2:0] CNT_OR  = 3'b011;
  localparam logic [2:0] CNT_SLT = 3'b100;
  localparam logic [2:0] CNT_MUL = 3'b101;
  localparam logic [2:0] CNT_DIV = 3'b110;
  localparam logic [2:0] CNT_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider datapath
module muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_t;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  // hi:lo is the product accumulator for mul, remainder:quotient for divide
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_rem_t = {r_hi, r_lo[WIDTH-1]};
    w_ge    = (w_rem_t >= {1'b0, r_opb});
    w_diff  = w_rem_t[WIDTH-1:0] - r_opb;
    if (r_is_div) begin
      w_hi_n = w_ge ? w_diff : w_rem_t[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_hi     <= '0;
      r_lo     <= i_op_a;
      r_opb    <= i_op_b;
      r_cnt    <= '0;
      r_is_div <= i_is_div;
    end else if (i_step) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // outputs are the post-step values so the controller can capture them on the final edge
  assign o_last = (r_cnt == CW'(WIDTH - 1));
  assign o_lo   = w_lo_n;
  assign o_hi   = w_hi_n;

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU control decoder with sequenced multi-cycle mul/divu/remu unit
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ALUOp,
  input  logic [FUNC_W-1:0] Function,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  output logic [2:0]        ALUcnt,
  output logic              illegal,
  output logic              stall,
  output logic              md_done,
  output logic [WIDTH-1:0]  md_lo,
  output logic [WIDTH-1:0]  md_hi,
  output logic              div_by_zero
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_md_lo;
  logic [WIDTH-1:0] r_md_hi;
  logic             r_dbz;

  logic             w_md_fn;
  logic             w_is_div;
  logic             w_start;
  logic             w_dbz_start;
  logic             w_busy;
  logic             w_last;
  logic             w_finish;
  logic [WIDTH-1:0] w_res_lo;
  logic [WIDTH-1:0] w_res_hi;

  always_comb begin
    ALUcnt  = CNT_ADD;
    illegal = 1'b0;
    case (ALUOp)
      OP_ADD: ALUcnt = CNT_ADD;
      OP_SUB: ALUcnt = CNT_SUB;
      OP_SLT: ALUcnt = CNT_SLT;
      default: begin
        case (Function)
          FUNC_W'(FN_ADD):  ALUcnt = CNT_ADD;
          FUNC_W'(FN_SUB):  ALUcnt = CNT_SUB;
          FUNC_W'(FN_AND):  ALUcnt = CNT_AND;
          FUNC_W'(FN_OR):   ALUcnt = CNT_OR;
          FUNC_W'(FN_SLT):  ALUcnt = CNT_SLT;
          FUNC_W'(FN_MUL):  ALUcnt = CNT_MUL;
          FUNC_W'(FN_DIVU): ALUcnt = CNT_DIV;
          FUNC_W'(FN_REMU): ALUcnt = CNT_DIV;
          default: begin
            ALUcnt  = CNT_ILL;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign w_md_fn     = (ALUOp == OP_RTYPE) &&
                       ((Function == FUNC_W'(FN_MUL)) || (Function == FUNC_W'(FN_DIVU)) ||
                        (Function == FUNC_W'(FN_REMU)));
  assign w_is_div    = (Function != FUNC_W'(FN_MUL));
  // flush wins over a same-cycle start, so it masks acceptance outright
  assign w_start     = in_valid && w_md_fn && (r_state == ST_IDLE) && !flush;
  assign w_dbz_start = w_start && w_is_div && (op_b == '0);
  assign w_busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_finish    = w_busy && w_last && !flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (!w_is_div)         w_state_nxt = ST_MUL;
          else if (w_dbz_start)  w_state_nxt = ST_DONE;
          else                   w_state_nxt = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (w_last) w_state_nxt = ST_DONE;
      default:        w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_md_lo <= '0;
      r_md_hi <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_dbz_start) begin
        r_md_lo <= '1;
        r_md_hi <= op_a;
        r_dbz   <= 1'b1;
      end else if (w_finish) begin
        r_md_lo <= w_res_lo;
        r_md_hi <= w_res_hi;
        r_dbz   <= 1'b0;
      end
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_start),
    .i_is_div (w_is_div),
    .i_step   (w_busy),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .o_last   (w_last),
    .o_lo     (w_res_lo),
    .o_hi     (w_res_hi)
  );

  assign stall       = w_busy || w_start;
  assign md_done     = (r_state == ST_DONE);
  assign div_by_zero = r_dbz && (r_state == ST_DONE);
  assign md_lo       = r_md_lo;
  assign md_hi       = r_md_hi;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - randomized self-checking bench for alu_seq_ctrl at WIDTH=8
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ALUOp;
  logic [3:0] Function;
  logic       in_valid;
  logic       flush;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [2:0] ALUcnt;
  logic       illegal;
  logic       stall;
  logic       md_done;
  logic [7:0] md_lo;
  logic [7:0] md_hi;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_last_lo = 8'h00;
  logic [7:0] exp_last_hi = 8'h00;

  alu_seq_ctrl #(.WIDTH(8), .FUNC_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALUOp       (ALUOp),
    .Function    (Function),
    .in_valid    (in_valid),
    .flush       (flush),
    .op_a        (op_a),
    .op_b        (op_b),
    .ALUcnt      (ALUcnt),
    .illegal     (illegal),
    .stall       (stall),
    .md_done     (md_done),
    .md_lo       (md_lo),
    .md_hi       (md_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // {illegal, ALUcnt} from the decode table
  function automatic logic [3:0] ref_dec(input logic [1:0] aluop, input logic [3:0] fn);
    int f;
    f = int'(fn);
    if (aluop == 2'b11) return 4'd0;
    if (aluop == 2'b01) return 4'd1;
    if (aluop == 2'b10) return 4'd4;
    if (f < 5)  return {1'b0, 3'(f)};
    if (f == 5) return 4'd5;
    if (f < 8)  return 4'd6;
    return 4'b1111;
  endfunction

  // {div_by_zero, hi, lo}
  function automatic logic [16:0] ref_md(input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, p;
    ia = int'(a);
    ib = int'(b);
    if (fn == 4'd5) begin
      p = ia * ib;
      return {1'b0, 16'(p)};
    end
    if (ib == 0) return {1'b1, a, 8'hFF};
    return {1'b0, 8'(ia % ib), 8'(ia / ib)};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the md_done cycle (or after the cycle bound).
  task automatic do_op(input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b, input bit poke,
                       output int lat, output logic [7:0] lo, output logic [7:0] hi,
                       output logic dbz, output bit stall_ok);
    stall_ok = 1'b1;
    ALUOp = 2'b00; Function = fn; op_a = a; op_b = b; in_valid = 1'b1;
    #1;
    if (stall !== 1'b1) stall_ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);
    lat = 1;
    while (md_done !== 1'b1 && lat < 40) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (poke && lat == 3) begin
        in_valid = 1'b1; Function = 4'b0101; op_a = 8'd1; op_b = 8'd1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end
    lo = md_lo; hi = md_hi; dbz = div_by_zero;
    if (stall !== 1'b0) stall_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ALUOp = 2'b11; Function = 4'd0; op_a = 8'd0; op_b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({md_done, div_by_zero, stall, md_lo, md_hi} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state: got done=%b dbz=%b stall=%b lo=%h hi=%h, want all 0",
               md_done, div_by_zero, stall, md_lo, md_hi);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decode;
    logic [1:0] ops[3] = '{2'b00, 2'b00, 2'b11};
    logic [3:0] fns[3] = '{4'b0011, 4'b1111, 4'b0000};
    logic [3:0] e;
    for (int i = 0; i < 3; i++) begin
      ALUOp = ops[i]; Function = fns[i]; #1;
      e = ref_dec(ops[i], fns[i]);
      total++;
      if ({illegal, ALUcnt} !== e) begin
        bad++;
        $display("FAIL decode_directed[%0d]: got ill=%b cnt=%b, want ill=%b cnt=%b", i, illegal, ALUcnt, e[3], e[2:0]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      ALUOp = 2'($urandom); Function = 4'($urandom); #1;
      e = ref_dec(ALUOp, Function);
      total++;
      if ({illegal, ALUcnt} !== e) begin
        bad++;
        $display("FAIL decode_random: op=%b fn=%b got ill=%b cnt=%b, want ill=%b cnt=%b",
                 ALUOp, Function, illegal, ALUcnt, e[3], e[2:0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_decode_busy;
    logic [3:0] e;
    int cyc;
    ALUOp = 2'b00; Function = 4'd5; op_a = 8'd7; op_b = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (md_done !== 1'b1 && cyc < 40) begin
      ALUOp = 2'($urandom); Function = 4'($urandom); #1;
      e = ref_dec(ALUOp, Function);
      total++;
      if ({illegal, ALUcnt} !== e) begin
        bad++;
        $display("FAIL decode_busy: op=%b fn=%b got ill=%b cnt=%b, want ill=%b cnt=%b",
                 ALUOp, Function, illegal, ALUcnt, e[3], e[2:0]);
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (md_done !== 1'b1 || md_lo !== 8'd63 || md_hi !== 8'd0) begin
      bad++;
      $display("FAIL decode_busy_result: got done=%b lo=%h hi=%h, want done=1 lo=3f hi=00", md_done, md_lo, md_hi);
    end
    exp_last_lo = 8'd63; exp_last_hi = 8'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int lat; logic [7:0] lo, hi; logic dbz; bit sok;
    do_op(4'd5, 8'd13, 8'd11, 1'b0, lat, lo, hi, dbz, sok);
    total++;
    if (lat != 9 || lo !== 8'h8F || hi !== 8'h00 || dbz !== 1'b0) begin
      bad++;
      $display("FAIL mul_13x11: got lat=%0d lo=%h hi=%h dbz=%b, want lat=9 lo=8f hi=00 dbz=0", lat, lo, hi, dbz);
    end
    total++;
    if (!sok) begin
      bad++;
      $display("FAIL mul_stall: got stall pattern wrong, want 1 on cycles 0..8 and 0 on cycle 9");
    end
    @(posedge clk); #1;
    total++;
    if (md_done !== 1'b0 || md_lo !== 8'h8F || md_hi !== 8'h00) begin
      bad++;
      $display("FAIL mul_hold: got done=%b lo=%h hi=%h, want done=0 lo=8f hi=00", md_done, md_lo, md_hi);
    end
    do_op(4'd5, 8'd200, 8'd200, 1'b0, lat, lo, hi, dbz, sok);
    total++;
    if (lat != 9 || lo !== 8'h40 || hi !== 8'h9C) begin
      bad++;
      $display("FAIL mul_200x200: got lat=%0d lo=%h hi=%h, want lat=9 lo=40 hi=9c", lat, lo, hi);
    end
    exp_last_lo = 8'h40; exp_last_hi = 8'h9C;
    @(posedge clk); #1;
  endtask

  task automatic test_divu;
    int lat; logic [7:0] lo, hi; logic dbz; bit sok;
    do_op(4'd6, 8'd100, 8'd7, 1'b1, lat, lo, hi, dbz, sok);
    total++;
    if (lat != 9 || lo !== 8'd14 || hi !== 8'd2 || dbz !== 1'b0 || !sok) begin
      bad++;
      $display("FAIL divu_100_7: got lat=%0d q=%0d r=%0d dbz=%b stall_ok=%0d, want lat=9 q=14 r=2 dbz=0 stall_ok=1",
               lat, lo, hi, dbz, sok);
    end
    @(posedge clk); #1;
    repeat (12) begin
      total++;
      if (md_done !== 1'b0 || stall !== 1'b0) begin
        bad++;
        $display("FAIL divu_busy_ignored: got done=%b stall=%b, want 0 0", md_done, stall);
      end
      @(posedge clk); #1;
    end
    exp_last_lo = 8'd14; exp_last_hi = 8'd2;
  endtask

  task automatic test_div_zero;
    int lat; logic [7:0] lo, hi; logic dbz; bit sok;
    do_op(4'd7, 8'd5, 8'd0, 1'b0, lat, lo, hi, dbz, sok);
    total++;
    if (lat != 1 || lo !== 8'hFF || hi !== 8'd5 || dbz !== 1'b1) begin
      bad++;
      $display("FAIL div_zero: got lat=%0d lo=%h hi=%h dbz=%b, want lat=1 lo=ff hi=05 dbz=1", lat, lo, hi, dbz);
    end
    @(posedge clk); #1;
    total++;
    if (md_done !== 1'b0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL div_zero_after: got done=%b dbz=%b, want 0 0", md_done, div_by_zero);
    end
    exp_last_lo = 8'hFF; exp_last_hi = 8'd5;
  endtask

  task automatic test_flush_mid;
    int lat; logic [7:0] lo, hi; logic dbz; bit sok; bit seen;
    ALUOp = 2'b00; Function = 4'd5; op_a = 8'd13; op_b = 8'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (stall !== 1'b0 || md_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle: got stall=%b done=%b, want 0 0", stall, md_done);
    end
    seen = 1'b0;
    repeat (12) begin if (md_done !== 1'b0) seen = 1'b1; @(posedge clk); #1; end
    total++;
    if (seen || md_lo !== exp_last_lo || md_hi !== exp_last_hi) begin
      bad++;
      $display("FAIL flush_no_done: got seen=%0d lo=%h hi=%h, want seen=0 lo=%h hi=%h",
               seen, md_lo, md_hi, exp_last_lo, exp_last_hi);
    end
    Function = 4'd6; op_b = 8'd3; in_valid = 1'b1; flush = 1'b1; #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_vs_start: got stall=%b, want 0", stall);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (12) begin if (md_done !== 1'b0 || stall !== 1'b0) seen = 1'b1; @(posedge clk); #1; end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL flush_vs_start_idle: got activity=1, want 0");
    end
    do_op(4'd5, 8'd3, 8'd3, 1'b0, lat, lo, hi, dbz, sok);
    total++;
    if (lat != 9 || lo !== 8'd9 || hi !== 8'd0) begin
      bad++;
      $display("FAIL flush_restart: got lat=%0d lo=%h hi=%h, want lat=9 lo=09 hi=00", lat, lo, hi);
    end
    exp_last_lo = 8'd9; exp_last_hi = 8'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid;
    int lat; logic [7:0] lo, hi; logic dbz; bit sok; bit seen;
    ALUOp = 2'b00; Function = 4'd5; op_a = 8'd200; op_b = 8'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({md_done, div_by_zero, stall, md_lo, md_hi} !== 19'd0) begin
      bad++;
      $display("FAIL rst_async: got done=%b dbz=%b stall=%b lo=%h hi=%h, want all 0",
               md_done, div_by_zero, stall, md_lo, md_hi);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(4'd5, 8'd3, 8'd3, 1'b0, lat, lo, hi, dbz, sok);
    total++;
    if (lat != 9 || lo !== 8'd9 || hi !== 8'd0 || !sok) begin
      bad++;
      $display("FAIL rst_restart: got lat=%0d lo=%h hi=%h stall_ok=%0d, want lat=9 lo=09 hi=00 stall_ok=1",
               lat, lo, hi, sok);
    end
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (10) begin if (md_done !== 1'b0) seen = 1'b1; @(posedge clk); #1; end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rst_no_stale_done: got extra md_done, want none");
    end
    exp_last_lo = 8'd9; exp_last_hi = 8'd0;
  endtask

  task automatic test_random_ops;
    int lat; logic [7:0] lo, hi, a, b; logic dbz; bit sok;
    logic [3:0] fn; logic [16:0] e;
    for (int i = 0; i < 30; i++) begin
      fn = 4'(5 + $urandom_range(0, 2));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      e  = ref_md(fn, a, b);
      do_op(fn, a, b, 1'b0, lat, lo, hi, dbz, sok);
      total++;
      if ({dbz, hi, lo} !== e || lat != ((fn != 4'd5 && b == 8'd0) ? 1 : 9) || !sok) begin
        bad++;
        $display("FAIL random_op: fn=%0d a=%0d b=%0d got dbz=%b hi=%h lo=%h lat=%0d stall_ok=%0d, want dbz=%b hi=%h lo=%h",
                 fn, a, b, dbz, hi, lo, lat, sok, e[16], e[15:8], e[7:0]);
      end
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_decode_busy;
    test_mul;
    test_divu;
    test_div_zero;
    test_flush_mid;
    test_rst_mid;
    test_random_ops;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
